// File: rtl/rf_pkg.sv
// Shared constants for the parametrised register file: clear-sequencer states and default sizes.
package rf_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 2;

endpackage

// File: rtl/rf_param.sv
// Parametrised register file with optional write bypass, per-register lock scoreboard
// and a sequenced one-register-per-cycle hardware clear.
module rf_param
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned BYPASS = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          reg1,
  input  logic [ADDR_W-1:0]          reg2,
  input  logic [ADDR_W-1:0]          regw,
  input  logic [DATA_W-1:0]          dataw,
  input  logic                       RFWrite,
  input  logic                       lock_req,
  input  logic [ADDR_W-1:0]          lock_reg,
  input  logic                       clr_start,
  output logic [DATA_W-1:0]          data1,
  output logic [DATA_W-1:0]          data2,
  output logic                       busy1,
  output logic                       busy2,
  output logic                       clr_busy,
  output logic                       clr_done,
  output logic [DATA_W*(2**ADDR_W)-1:0] rall
);

  localparam int unsigned NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

  rf_state_e          state_q, state_d;
  logic [ADDR_W:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]  regs_q [NREGS];
  logic [DATA_W-1:0]  regs_d [NREGS];
  logic [NREGS-1:0]   lock_q, lock_d;
  logic               clr_busy_q, clr_busy_d;
  logic               clr_done_q, clr_done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    lock_d  = lock_q;
    unique case (state_q)
      RF_IDLE: begin
        if (clr_start) begin
          state_d = RF_CLEAR;
          cnt_d   = '0;
        end else begin
          if (RFWrite) begin
            regs_d[regw] = dataw;
            lock_d[regw] = 1'b0;
          end
          // Applied after the write so a same-register lock wins.
          if (lock_req) lock_d[lock_reg] = 1'b1;
        end
      end
      RF_CLEAR: begin
        regs_d[cnt_q[ADDR_W-1:0]] = '0;
        lock_d[cnt_q[ADDR_W-1:0]] = 1'b0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = RF_IDLE;
      end
      default: state_d = RF_IDLE;
    endcase
    // Registered flags describe the cycle being entered.
    clr_busy_d = (state_d == RF_CLEAR);
    clr_done_d = (state_d == RF_CLEAR) && (cnt_d == LAST);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= RF_IDLE;
      cnt_q      <= '0;
      regs_q     <= '{default: '0};
      lock_q     <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      regs_q     <= regs_d;
      lock_q     <= lock_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
    end
  end

  logic fwd_ok;
  assign fwd_ok = (BYPASS != 0) && RFWrite && (state_q == RF_IDLE);

  always_comb begin
    data1 = regs_q[reg1];
    data2 = regs_q[reg2];
    if (fwd_ok && (regw == reg1)) data1 = dataw;
    if (fwd_ok && (regw == reg2)) data2 = dataw;
  end

  assign busy1    = lock_q[reg1];
  assign busy2    = lock_q[reg2];
  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

  for (genvar i = 0; i < NREGS; i++) begin : g_rall
    assign rall[i*DATA_W +: DATA_W] = regs_q[i];
  end

endmodule

// File: tb/tb_rf_param.sv
// Scoreboard bench for rf_param: per-cycle expectations from a queue-based model, plus a
// directed run on a 16x8 instance.
module tb_rf_param;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] reg1 = '0, reg2 = '0, regw = '0, lock_reg = '0;
  logic [7:0] dataw = '0;
  logic       RFWrite = 1'b0, lock_req = 1'b0, clr_start = 1'b0;

  logic [7:0]  data1, data2, nb_data1, nb_data2;
  logic        busy1, busy2, clr_busy, clr_done;
  logic        nb_busy1, nb_busy2, nb_clr_busy, nb_clr_done;
  logic [31:0] rall, nb_rall;

  logic [2:0]   w_reg1 = '0, w_reg2 = '0, w_regw = '0, w_lock_reg = '0;
  logic [15:0]  w_dataw = '0;
  logic         w_we = 1'b0, w_lock_req = 1'b0, w_clr_start = 1'b0;
  logic [15:0]  w_data1, w_data2;
  logic         w_busy1, w_busy2, w_clr_busy, w_clr_done;
  logic [127:0] w_rall;

  always #5 clock = ~clock;

  rf_param u_dut (
    .clock(clock), .reset(reset), .reg1(reg1), .reg2(reg2), .regw(regw), .dataw(dataw),
    .RFWrite(RFWrite), .lock_req(lock_req), .lock_reg(lock_reg), .clr_start(clr_start),
    .data1(data1), .data2(data2), .busy1(busy1), .busy2(busy2), .clr_busy(clr_busy),
    .clr_done(clr_done), .rall(rall)
  );

  rf_param #(.BYPASS(0)) u_nb (
    .clock(clock), .reset(reset), .reg1(reg1), .reg2(reg2), .regw(regw), .dataw(dataw),
    .RFWrite(RFWrite), .lock_req(lock_req), .lock_reg(lock_reg), .clr_start(clr_start),
    .data1(nb_data1), .data2(nb_data2), .busy1(nb_busy1), .busy2(nb_busy2),
    .clr_busy(nb_clr_busy), .clr_done(nb_clr_done), .rall(nb_rall)
  );

  rf_param #(.DATA_W(16), .ADDR_W(3)) u_wide (
    .clock(clock), .reset(reset), .reg1(w_reg1), .reg2(w_reg2), .regw(w_regw),
    .dataw(w_dataw), .RFWrite(w_we), .lock_req(w_lock_req), .lock_reg(w_lock_reg),
    .clr_start(w_clr_start), .data1(w_data1), .data2(w_data2), .busy1(w_busy1),
    .busy2(w_busy2), .clr_busy(w_clr_busy), .clr_done(w_clr_done), .rall(w_rall)
  );

  typedef struct {
    logic [7:0]  d1, d2, n1, n2;
    logic        b1, b2, cb, cd;
    logic [31:0] ra;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem[4];
  bit         lk[4];
  int         clr_q[$];   // register indices still to be cleared, one per cycle
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("data1", data1, e.d1);
      chk("data2", data2, e.d2);
      chk("nb_data1", nb_data1, e.n1);
      chk("nb_data2", nb_data2, e.n2);
      chk("busy1", busy1, e.b1);
      chk("busy2", busy2, e.b2);
      chk("clr_busy", clr_busy, e.cb);
      chk("clr_done", clr_done, e.cd);
      chk("rall", rall, e.ra);
      chk("nb_rall", nb_rall, e.ra);
    end
  end

  // One cycle of stimulus: expectation is formed from the state left by the previous edge.
  task automatic drive(input logic rst, input logic [1:0] r1, input logic [1:0] r2,
                       input logic [1:0] rw, input logic [7:0] dw, input logic we,
                       input logic lr, input logic [1:0] lreg, input logic cs);
    exp_t e;
    bit   fwd;
    @(posedge clock);
    #1;
    reset = rst; reg1 = r1; reg2 = r2; regw = rw; dataw = dw;
    RFWrite = we; lock_req = lr; lock_reg = lreg; clr_start = cs;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin mem[i] = '0; lk[i] = 0; end
      clr_q.delete();
    end
    fwd  = we && (clr_q.size() == 0) && !rst;
    e.d1 = (fwd && rw == r1) ? dw : mem[r1];
    e.d2 = (fwd && rw == r2) ? dw : mem[r2];
    e.n1 = mem[r1];
    e.n2 = mem[r2];
    e.b1 = lk[r1];
    e.b2 = lk[r2];
    e.cb = (clr_q.size() != 0);
    e.cd = (clr_q.size() == 1);
    for (int i = 0; i < 4; i++) e.ra[i*8 +: 8] = mem[i];
    exp_q.push_back(e);
    if (!rst) begin
      if (clr_q.size() != 0) begin
        int k;
        k = clr_q.pop_front();
        mem[k] = '0;
        lk[k]  = 0;
      end else if (cs) begin
        for (int i = 0; i < 4; i++) clr_q.push_back(i);
      end else begin
        if (we) begin mem[rw] = dw; lk[rw] = 0; end
        if (lr) lk[lreg] = 1;
      end
    end
  endtask

  task automatic idle(input logic [1:0] r1, input logic [1:0] r2);
    drive(1'b0, r1, r2, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin mem[i] = '0; lk[i] = 0; end
    repeat (2) @(posedge clock);
    drive(1'b1, 2'd0, 2'd1, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    idle(2'd0, 2'd1);

    // Basic write then read back.
    drive(1'b0, 2'd2, 2'd0, 2'd2, 8'hA5, 1'b1, 1'b0, 2'd0, 1'b0);
    idle(2'd2, 2'd0);
    #1;
    chk("rall_r2_A5", rall[23:16], 8'hA5);
    chk("data1_A5", data1, 8'hA5);
    chk("rall_others0", {rall[31:24], rall[15:0]}, 24'h0);

    // Same-cycle bypass on both ports (u_nb must show the old value).
    drive(1'b0, 2'd3, 2'd3, 2'd3, 8'h3C, 1'b1, 1'b0, 2'd0, 1'b0);
    #1;
    chk("bypass_d1", data1, 8'h3C);
    chk("nobypass_d1", nb_data1, 8'h00);

    // Lock, write clears lock, lock beats same-cycle write.
    drive(1'b0, 2'd1, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd1, 1'b0);
    idle(2'd1, 2'd0);
    drive(1'b0, 2'd1, 2'd0, 2'd1, 8'h11, 1'b1, 1'b0, 2'd0, 1'b0);
    idle(2'd1, 2'd0);
    drive(1'b0, 2'd1, 2'd0, 2'd1, 8'h22, 1'b1, 1'b1, 2'd1, 1'b0);
    idle(2'd1, 2'd0);
    #1;
    chk("lock_wins_busy", busy1, 1'b1);
    chk("lock_wins_data", data1, 8'h22);

    // Fill, clear with a write attempted mid-clear.
    for (int i = 0; i < 4; i++)
      drive(1'b0, 2'(i), 2'd0, 2'(i), 8'(8'h90 + i), 1'b1, 1'b1, 2'(3 - i), 1'b0);
    drive(1'b0, 2'd0, 2'd1, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1);
    idle(2'd0, 2'd1);
    drive(1'b0, 2'd2, 2'd2, 2'd2, 8'h77, 1'b1, 1'b1, 2'd2, 1'b1);
    idle(2'd2, 2'd3);
    idle(2'd2, 2'd3);
    idle(2'd0, 2'd2);

    // Reset during the second clear cycle.
    for (int i = 0; i < 4; i++)
      drive(1'b0, 2'd0, 2'd0, 2'(i), 8'(8'h50 + i), 1'b1, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 2'd0, 2'd1, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1);
    idle(2'd0, 2'd1);
    drive(1'b1, 2'd2, 2'd3, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) idle(2'(i), 2'(i + 1));

    // Randomized traffic.
    for (int c = 0; c < 600; c++)
      drive(1'b0, 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            2'($urandom), ($urandom_range(0, 24) == 0));
    drive(1'b1, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    idle(2'd0, 2'd0);
    repeat (2) @(negedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);

    // 16-bit x 8 instance.
    @(posedge clock); #1;
    w_regw = 3'd7; w_dataw = 16'hFFFF; w_we = 1'b1;
    @(posedge clock); #1;
    w_we = 1'b0;
    #1 chk("w_r7_ffff", w_rall[127:112], 16'hFFFF);
    @(posedge clock); #1;
    w_clr_start = 1'b1;
    @(posedge clock); #1;
    w_clr_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k != 0) begin @(posedge clock); #1; end
      chk("w_clr_busy", w_clr_busy, 1'b1);
      chk("w_clr_done", w_clr_done, (k == 7));
    end
    @(posedge clock); #1;
    chk("w_clr_busy_end", w_clr_busy, 1'b0);
    chk("w_clr_done_end", w_clr_done, 1'b0);
    chk("w_rall_zero", w_rall, 128'h0);
    w_regw = 3'd0; w_dataw = 16'h1234; w_we = 1'b1; w_reg1 = 3'd0;
    #1 chk("w_bypass", w_data1, 16'h1234);
    @(posedge clock); #1;
    w_we = 1'b0;
    chk("w_r7_zero", w_rall[127:112], 16'h0000);
    chk("w_r0_1234", w_rall[15:0], 16'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
